// File: rtl/spi_cmd_seq.sv
// spi_cmd_seq: command FIFO plus four-phase rdy/req/ack sequencer feeding the SPI master
//   spi_clk/spi_rst        clock shared with the master, async active-high reset
//   cmd_valid/ready/data   command push port (ready = FIFO not full)
//   rsp_valid/ready/data   read-back word per command, in command order
//   busy, fifo_level       FIFO non-empty or frame in progress; FIFO occupancy
//   xfer_cnt               completed frames, wraps at 16 bits
//   m_rdy/m_req/m_ack      master handshake; m_din/m_dout master SPI_IN/SPI_OUT
module spi_cmd_seq #(
    parameter int DEPTH = 8,
    parameter int DW    = 16
) (
    input  logic                     spi_clk,
    input  logic                     spi_rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [DW-1:0]            cmd_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DW-1:0]            rsp_data,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [15:0]              xfer_cnt,
    input  logic                     m_rdy,
    output logic                     m_req,
    input  logic                     m_ack,
    input  logic [DW-1:0]            m_din,
    output logic [DW-1:0]            m_dout
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL} state_t;
    state_t        state;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop, cap;
    assign cmd_ready = fifo_level != (AW+1)'(DEPTH);
    assign push      = cmd_valid & cmd_ready;
    assign pop       = state == S_IDLE && fifo_level != '0 && m_rdy;
    // capture is held off while an unconsumed response is pending; m_req stays up meanwhile
    assign cap       = state == S_REQ && m_ack && !rsp_valid;
    assign busy      = fifo_level != '0 || state != S_IDLE;
    always_ff @(posedge spi_clk)
        if (push) mem[wr_ptr] <= cmd_data;
    always_ff @(posedge spi_clk or posedge spi_rst) begin
        if (spi_rst) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            xfer_cnt   <= '0;
            m_req      <= 1'b0;
            m_dout     <= '0;
        end else begin
            wr_ptr     <= wr_ptr + AW'(push);
            rd_ptr     <= rd_ptr + AW'(pop);
            fifo_level <= fifo_level + (AW+1)'(push) - (AW+1)'(pop);
            rsp_valid  <= cap | (rsp_valid & ~rsp_ready);
            case (state)
                S_IDLE: if (pop) begin
                    m_dout <= mem[rd_ptr];
                    m_req  <= 1'b1;
                    state  <= S_REQ;
                end
                S_REQ: if (cap) begin
                    rsp_data <= m_din;
                    xfer_cnt <= xfer_cnt + 16'd1;
                    m_req    <= 1'b0;
                    state    <= S_REL;
                end
                S_REL: if (!m_ack) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_cmd_seq.sv
// tb_spi_cmd_seq: directed and randomized checks of spi_cmd_seq against a behavioural SPI master
module tb_spi_cmd_seq;
    logic        spi_clk = 0, spi_rst = 1, cmd_valid = 0, rsp_ready = 0, m_rdy = 0, m_ack = 0, rdy_en = 1;
    logic        cmd_ready, rsp_valid, busy, m_req;
    logic [15:0] cmd_data = 0, m_din = 0, rsp_data, m_dout, xfer_cnt;
    logic [3:0]  fifo_level;
    int          total = 0, bad = 0;
    int          mst_st = 0, mst_cnt = 0;
    logic [15:0] mst_word = 0;
    logic        prev_req = 0;
    logic [15:0] prev_dout = 0;
    logic [15:0] q[$];

    spi_cmd_seq dut (
        .spi_clk(spi_clk), .spi_rst(spi_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .fifo_level(fifo_level), .xfer_cnt(xfer_cnt),
        .m_rdy(m_rdy), .m_req(m_req), .m_ack(m_ack), .m_din(m_din), .m_dout(m_dout)
    );

    always #5 spi_clk = ~spi_clk;

    function automatic logic [15:0] resp_of(input logic [15:0] w);
        return w ^ 16'hB7F7;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge spi_clk);
        #1;
    endtask

    task automatic push(input logic [15:0] w);
        cmd_data  = w;
        cmd_valid = 1;
        tick;
        cmd_valid = 0;
    endtask

    task automatic wait_rsp(input logic [15:0] exp, input string tag);
        int n = 0;
        while (!rsp_valid && n < 200) begin
            tick;
            n++;
        end
        chk({tag, "_v"}, rsp_valid, 1);
        chk(tag, rsp_data, exp);
        rsp_ready = 1;
        tick;
        rsp_ready = 0;
    endtask

    task automatic idle_wait(input string tag);
        int n = 0;
        while ((busy || rsp_valid || mst_st != 0) && n < 200) begin
            tick;
            n++;
        end
        chk({tag, "_idle"}, n < 200, 1);
    endtask

    // master model: drops rdy on req, acks two cycles later, releases ack after req falls
    initial forever begin
        @(posedge spi_clk);
        #2;
        if (spi_rst) begin
            mst_st = 0;
            m_ack  = 0;
            m_rdy  = rdy_en;
        end else case (mst_st)
            0: begin
                m_rdy = rdy_en;
                if (m_req) begin
                    mst_word = m_dout;
                    m_rdy    = 0;
                    mst_cnt  = 0;
                    mst_st   = 1;
                end
            end
            1: begin
                mst_cnt++;
                if (mst_cnt == 2) begin
                    m_din  = resp_of(mst_word);
                    m_ack  = 1;
                    mst_st = 2;
                end
            end
            2: if (!m_req) begin
                m_ack  = 0;
                mst_st = 3;
            end
            default: begin
                m_rdy  = rdy_en;
                mst_st = 0;
            end
        endcase
    end

    always @(negedge spi_clk) begin
        if (m_req && prev_req) chk("dout_stable", m_dout, prev_dout);
        prev_req  <= m_req;
        prev_dout <= m_dout;
    end

    initial begin
        repeat (3) tick;
        spi_rst = 0;
        tick;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_xfer", xfer_cnt, 0);
        chk("rst_req", m_req, 0);
        chk("rst_dout", m_dout, 0);

        push(16'hA5C3);
        chk("t1_lvl1", fifo_level, 1);
        chk("t1_req0", m_req, 0);
        tick;
        chk("t1_dout", m_dout, 16'hA5C3);
        chk("t1_req1", m_req, 1);
        chk("t1_lvl0", fifo_level, 0);
        wait_rsp(16'h1234, "t1_rsp");
        chk("t1_cnt", xfer_cnt, 1);
        idle_wait("t1");

        rdy_en = 0;
        repeat (2) tick;
        for (int i = 0; i < 8; i++) push(16'h1100 + 16'(i));
        chk("t2_lvl8", fifo_level, 8);
        chk("t2_full", cmd_ready, 0);
        chk("t2_noreq", m_req, 0);
        push(16'hDEAD);
        chk("t2_refused", fifo_level, 8);
        rdy_en = 1;
        for (int i = 0; i < 8; i++) wait_rsp(resp_of(16'h1100 + 16'(i)), "t2_rsp");
        chk("t2_cnt", xfer_cnt, 9);
        idle_wait("t2");

        push(16'h3C01);
        push(16'h3C02);
        begin
            int n = 0;
            while (!(rsp_valid && m_req && m_ack) && n < 200) begin
                tick;
                n++;
            end
            chk("t3_stall_seen", n < 200, 1);
        end
        repeat (3) tick;
        chk("t3_req_held", m_req, 1);
        chk("t3_dout_w2", m_dout, 16'h3C02);
        chk("t3_rsp1_held", rsp_data, resp_of(16'h3C01));
        chk("t3_cnt_held", xfer_cnt, 10);
        wait_rsp(resp_of(16'h3C01), "t3_rsp1");
        wait_rsp(resp_of(16'h3C02), "t3_rsp2");
        chk("t3_cnt", xfer_cnt, 11);
        idle_wait("t3");

        for (int i = 1; i <= 4; i++) push(16'h4400 + 16'(i));
        chk("t4_req_pre", m_req, 1);
        chk("t4_lvl_pre", fifo_level, 3);
        spi_rst = 1;
        #1;
        chk("t4_req_async", m_req, 0);
        chk("t4_lvl", fifo_level, 0);
        chk("t4_rsp_valid", rsp_valid, 0);
        chk("t4_xfer", xfer_cnt, 0);
        chk("t4_busy", busy, 0);
        tick;
        spi_rst = 0;
        tick;
        chk("t4_ready", cmd_ready, 1);
        push(16'h7777);
        wait_rsp(resp_of(16'h7777), "t4_post_rsp");
        chk("t4_post_cnt", xfer_cnt, 1);
        idle_wait("t4");

        rdy_en = 0;
        tick;
        for (int i = 1; i <= 3; i++) push(16'h5500 + 16'(i));
        chk("t5_lvl3", fifo_level, 3);
        rdy_en    = 1;
        cmd_data  = 16'h5504;
        cmd_valid = 1;
        tick;
        cmd_valid = 0;
        chk("t5_lvl_same", fifo_level, 3);
        chk("t5_dout", m_dout, 16'h5501);
        for (int i = 1; i <= 4; i++) wait_rsp(resp_of(16'h5500 + 16'(i)), "t5_rsp");
        chk("t5_cnt", xfer_cnt, 5);
        idle_wait("t5");
        force dut.xfer_cnt = 16'hFFFE;
        tick;
        release dut.xfer_cnt;
        push(16'h6601);
        wait_rsp(resp_of(16'h6601), "t5_rsp_ffff");
        chk("t5_cnt_ffff", xfer_cnt, 16'hFFFF);
        push(16'h6602);
        wait_rsp(resp_of(16'h6602), "t5_rsp_wrap");
        chk("t5_cnt_wrap", xfer_cnt, 0);
        idle_wait("t5w");

        for (int c = 0; c < 400; c++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_data  = 16'($urandom);
            rsp_ready = $urandom_range(0, 2) != 0;
            rdy_en    = $urandom_range(0, 3) != 0;
            if (cmd_valid && cmd_ready) q.push_back(cmd_data);
            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) chk("t6_extra_rsp", 1, 0);
                else chk("t6_rsp", rsp_data, resp_of(q.pop_front()));
            end
            tick;
        end
        cmd_valid = 0;
        rsp_ready = 1;
        rdy_en    = 1;
        for (int n = 0; n < 2000 && q.size() > 0; n++) begin
            if (rsp_valid) chk("t6_drain_rsp", rsp_data, resp_of(q.pop_front()));
            tick;
        end
        chk("t6_drained", q.size(), 0);
        rsp_ready = 0;
        idle_wait("t6");
        chk("t6_level", fifo_level, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
